// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces a single
// pressed key and holds it as a one-hot code until a debounced release.
module keypad_scan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] onehot,
  output logic        key_pulse
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HOLD,
    ST_RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    row_m_q, row_s_q;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    col_q, col_d;
  logic [15:0]   onehot_q, onehot_d;
  logic          pulse_q, pulse_d;

  logic [3:0]    row_low;
  logic          single_low;
  logic [1:0]    row_enc;
  logic [CW-1:0] cnt_step;

  assign row_low    = ~row_s_q;
  assign single_low = (row_low != 4'h0) && ((row_low & (row_low - 4'd1)) == 4'h0);
  // The sample counter covers the accepting cycle itself, so acceptance fires
  // as the incremented count lands on its terminal value.
  assign cnt_step   = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    row_enc = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!row_s_q[i]) row_enc = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      row_m_q   <= '1;
      row_s_q   <= '1;
      state_q   <= ST_SCAN;
      col_idx_q <= '0;
      row_idx_q <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      pat_q     <= '1;
      col_q     <= 4'b1110;
      onehot_q  <= '0;
      pulse_q   <= 1'b0;
    end else begin
      row_m_q   <= row;
      row_s_q   <= row_m_q;
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      col_q     <= col_d;
      onehot_q  <= onehot_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    onehot_d  = onehot_q;
    pulse_d   = 1'b0;

    unique case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          if (single_low) begin
            pat_d     = row_s_q;
            row_idx_d = row_enc;
            cnt_d     = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
            dwell_d   = '0;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (row_s_q == pat_q) begin
          cnt_d = cnt_step;
          if (cnt_step == CNT_LAST) begin
            onehot_d = 16'h0001 << {row_idx_q, col_idx_q};
            pulse_d  = 1'b1;
            state_d  = ST_HOLD;
          end
        end else begin
          col_idx_d = col_idx_q + 2'd1;
          dwell_d   = '0;
          state_d   = ST_SCAN;
        end
      end

      ST_HOLD: begin
        if (row_s_q == 4'hF) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (row_s_q == 4'hF) begin
          cnt_d = cnt_step;
          if (cnt_step == CNT_LAST) begin
            onehot_d  = '0;
            col_idx_d = col_idx_q + 2'd1;
            dwell_d   = '0;
            state_d   = ST_SCAN;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: state_d = ST_SCAN;
    endcase

    col_d = ~(4'b0001 << col_idx_d);
  end

  assign col       = col_q;
  assign onehot    = onehot_q;
  assign key_pulse = pulse_q;

endmodule
